// File: rtl/shift_reg_univ_pkg.sv
// Shared op encoding and widths for shift_reg_univ and the blocks built on it.
package shift_reg_univ_pkg;

    localparam int OP_WIDTH = 3;

    typedef enum logic [OP_WIDTH-1:0] {
        OP_HOLD = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROTL = 3'b100,
        OP_ROTR = 3'b101,
        OP_CLR  = 3'b110,
        OP_SET  = 3'b111
    } op_e;

endpackage

// File: rtl/shift_reg_univ_if.sv
// Control/data bundle of shift_reg_univ; qn is present only when QN_OUT_EN is defined.
interface shift_reg_univ_if
    import shift_reg_univ_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic             i_en;
    op_e              i_op;
    logic [WIDTH-1:0] i_d;
    logic             i_sl_in;
    logic             i_sr_in;
    logic [WIDTH-1:0] o_q;
`ifdef QN_OUT_EN
    logic [WIDTH-1:0] o_qn;
`endif
    logic             o_msb_out;
    logic             o_lsb_out;
    logic             o_zero;

`ifdef QN_OUT_EN
    modport master (output i_en, i_op, i_d, i_sl_in, i_sr_in,
                    input  o_q, o_qn, o_msb_out, o_lsb_out, o_zero);
    modport slave  (input  i_en, i_op, i_d, i_sl_in, i_sr_in,
                    output o_q, o_qn, o_msb_out, o_lsb_out, o_zero);
`else
    modport master (output i_en, i_op, i_d, i_sl_in, i_sr_in,
                    input  o_q, o_msb_out, o_lsb_out, o_zero);
    modport slave  (input  i_en, i_op, i_d, i_sl_in, i_sr_in,
                    output o_q, o_msb_out, o_lsb_out, o_zero);
`endif

endinterface

// File: rtl/shift_reg_univ_bit.sv
// Single-bit cell of shift_reg_univ: next-state mux plus flop, optional complement flop (QN_OUT_EN).
module shift_reg_bit
    import shift_reg_univ_pkg::*;
#(
    parameter logic RESET_BIT = 1'b0
)(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_en,
    input  op_e  i_op,
    input  logic i_d,
    input  logic i_left,
    input  logic i_right,
    output logic o_next,
`ifdef QN_OUT_EN
    output logic o_qn,
`endif
    output logic o_q
);

    logic r_q;

    // Neighbour inputs already carry the serial or wrap bit at the edges.
    always_comb begin
        o_next = r_q;
        unique case (i_op)
            OP_HOLD: o_next = r_q;
            OP_LOAD: o_next = i_d;
            OP_SHL,
            OP_ROTL: o_next = i_left;
            OP_SHR,
            OP_ROTR: o_next = i_right;
            OP_CLR:  o_next = 1'b0;
            OP_SET:  o_next = 1'b1;
            default: o_next = r_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_q <= RESET_BIT;
        else if (i_en)
            r_q <= o_next;
    end

    assign o_q = r_q;

`ifdef QN_OUT_EN
    logic r_qn;

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_qn <= ~RESET_BIT;
        else if (i_en)
            r_qn <= ~o_next;
    end

    assign o_qn = r_qn;
`endif

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit shift register (load/shift/rotate/clear/set) with registered zero flag.
// Define QN_OUT_EN to add the registered complement output qn.
module shift_reg_univ
    import shift_reg_univ_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
)(
    input  logic             i_clk,
    input  logic             i_reset,
    shift_reg_univ_if.slave  bus
);

    localparam logic ZERO_AT_RESET = (RESET_VALUE == '0);

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_next;
    logic             w_feedLeft;
    logic             w_feedRight;
    logic             r_zero;

    // Edge cells see the serial input on a shift and the opposite end on a rotate.
    assign w_feedLeft  = (bus.i_op == OP_ROTL) ? w_q[WIDTH-1] : bus.i_sl_in;
    assign w_feedRight = (bus.i_op == OP_ROTR) ? w_q[0]       : bus.i_sr_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic w_left;
        logic w_right;

        if (i == 0) begin : g_lo
            assign w_left = w_feedLeft;
        end else begin : g_lo
            assign w_left = w_q[i-1];
        end

        if (i == WIDTH-1) begin : g_hi
            assign w_right = w_feedRight;
        end else begin : g_hi
            assign w_right = w_q[i+1];
        end

        shift_reg_bit #(
            .RESET_BIT (RESET_VALUE[i])
        ) u_bit (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_en    (bus.i_en),
            .i_op    (bus.i_op),
            .i_d     (bus.i_d[i]),
            .i_left  (w_left),
            .i_right (w_right),
            .o_next  (w_next[i]),
`ifdef QN_OUT_EN
            .o_qn    (bus.o_qn[i]),
`endif
            .o_q     (w_q[i])
        );
    end

    // Flag derives from next state so it never lags q.
    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_zero <= ZERO_AT_RESET;
        else if (bus.i_en)
            r_zero <= (w_next == '0);
    end

    assign bus.o_q       = w_q;
    assign bus.o_msb_out = w_q[WIDTH-1];
    assign bus.o_lsb_out = w_q[0];
    assign bus.o_zero    = r_zero;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Scoreboard bench for shift_reg_univ at WIDTH 4, 1 and 16 driven in lockstep.
module tb_shift_reg_univ;
    import shift_reg_univ_pkg::*;

    localparam logic [3:0]  RV4  = 4'b1010;
    localparam logic [0:0]  RV1  = 1'b1;
    localparam logic [15:0] RV16 = 16'hA5C3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    shift_reg_univ_if #(.WIDTH(4))  bus4();
    shift_reg_univ_if #(.WIDTH(1))  bus1();
    shift_reg_univ_if #(.WIDTH(16)) bus16();

    shift_reg_univ #(.WIDTH(4),  .RESET_VALUE(RV4))  dut4  (.i_clk(clk), .i_reset(reset), .bus(bus4.slave));
    shift_reg_univ #(.WIDTH(1),  .RESET_VALUE(RV1))  dut1  (.i_clk(clk), .i_reset(reset), .bus(bus1.slave));
    shift_reg_univ #(.WIDTH(16), .RESET_VALUE(RV16)) dut16 (.i_clk(clk), .i_reset(reset), .bus(bus16.slave));

    typedef struct {
        logic [63:0] q4;
        logic [63:0] q1;
        logic [63:0] q16;
    } expect_t;

    expect_t     sb[$];
    logic [63:0] mQ4, mQ1, mQ16;
    int          checkCount = 0;
    int          passCount  = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected)
            passCount++;
        else
            $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    endtask

    function automatic logic [63:0] modelNext(input logic [63:0] cur, input op_e op,
                                              input logic [63:0] d, input logic sl,
                                              input logic sr, input int w);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (op)
            OP_LOAD: r = d;
            OP_SHL:  r = (cur << 1) | 64'(sl);
            OP_SHR:  r = (cur >> 1) | (64'(sr) << (w-1));
            OP_ROTL: r = (cur << 1) | 64'(cur[w-1]);
            OP_ROTR: r = (cur >> 1) | (64'(cur[0]) << (w-1));
            OP_CLR:  r = '0;
            OP_SET:  r = '1;
            default: r = cur;
        endcase
        return r & mask;
    endfunction

    task automatic popAndCheck(input string tag);
        expect_t e;
        if (sb.size() == 0) begin
            checkOutput({tag, " sb_empty"}, 64'd1, 64'd0);
            return;
        end
        e = sb.pop_front();
        checkOutput({tag, " q4"},    64'(bus4.o_q),       e.q4);
        checkOutput({tag, " zero4"}, 64'(bus4.o_zero),    64'(e.q4 == 0));
        checkOutput({tag, " msb4"},  64'(bus4.o_msb_out), 64'(e.q4[3]));
        checkOutput({tag, " lsb4"},  64'(bus4.o_lsb_out), 64'(e.q4[0]));
        checkOutput({tag, " q1"},    64'(bus1.o_q),       e.q1);
        checkOutput({tag, " zero1"}, 64'(bus1.o_zero),    64'(e.q1 == 0));
        checkOutput({tag, " q16"},   64'(bus16.o_q),      e.q16);
        checkOutput({tag, " zero16"},64'(bus16.o_zero),   64'(e.q16 == 0));
`ifdef QN_OUT_EN
        checkOutput({tag, " qn4"},   64'(bus4.o_qn),      64'(~e.q4[3:0]));
        checkOutput({tag, " qn1"},   64'(bus1.o_qn),      64'(~e.q1[0]));
        checkOutput({tag, " qn16"},  64'(bus16.o_qn),     64'(~e.q16[15:0]));
`endif
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic en, input op_e op,
                                 input logic [63:0] d, input logic sl, input logic sr);
        expect_t e;
        @(negedge clk);
        reset         = rst;
        bus4.i_en     = en;  bus4.i_op  = op; bus4.i_d  = d[3:0];
        bus4.i_sl_in  = sl;  bus4.i_sr_in  = sr;
        bus1.i_en     = en;  bus1.i_op  = op; bus1.i_d  = d[0:0];
        bus1.i_sl_in  = sl;  bus1.i_sr_in  = sr;
        bus16.i_en    = en;  bus16.i_op = op; bus16.i_d = d[15:0];
        bus16.i_sl_in = sl;  bus16.i_sr_in = sr;
        if (!rst) begin
            mQ4 = 64'(RV4); mQ1 = 64'(RV1); mQ16 = 64'(RV16);
        end else if (en) begin
            mQ4  = modelNext(mQ4,  op, d & 64'hF,    sl, sr, 4);
            mQ1  = modelNext(mQ1,  op, d & 64'h1,    sl, sr, 1);
            mQ16 = modelNext(mQ16, op, d & 64'hFFFF, sl, sr, 16);
        end
        e.q4 = mQ4; e.q1 = mQ1; e.q16 = mQ16;
        sb.push_back(e);
        @(posedge clk);
        #1;
        popAndCheck(tag);
    endtask

    initial begin
        mQ4 = '0; mQ1 = '0; mQ16 = '0;
        $display("[TB] start");
        applyStimulus("rst0",   0, 0, OP_HOLD, 64'h0, 0, 0);
        applyStimulus("rst1",   0, 1, OP_SET,  64'h0, 0, 0);
        applyStimulus("en_off", 1, 0, OP_LOAD, 64'hFFFF, 1, 1);
        applyStimulus("ld1",    1, 1, OP_LOAD, 64'h0001, 0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("shl", 1, 1, OP_SHL, 64'h0, 1, 0);
        applyStimulus("ld8",    1, 1, OP_LOAD, 64'h8008, 0, 0);
        applyStimulus("rotl",   1, 1, OP_ROTL, 64'h0, 0, 0);
        applyStimulus("rotr_a", 1, 1, OP_ROTR, 64'h0, 0, 0);
        applyStimulus("rotr_b", 1, 1, OP_ROTR, 64'h0, 0, 0);
        applyStimulus("ld6",    1, 1, OP_LOAD, 64'h0006, 0, 0);
        applyStimulus("shr",    1, 1, OP_SHR,  64'h0, 0, 1);
        applyStimulus("midrst", 0, 1, OP_SHR,  64'h0, 0, 1);
        applyStimulus("shr_rv", 1, 1, OP_SHR,  64'h0, 0, 1);
        applyStimulus("hold_en",1, 0, OP_SHR,  64'h0, 1, 1);
        applyStimulus("ld1b",   1, 1, OP_LOAD, 64'h0001, 0, 0);
        applyStimulus("shr0",   1, 1, OP_SHR,  64'h0, 0, 0);
        applyStimulus("set",    1, 1, OP_SET,  64'h0, 0, 0);
        applyStimulus("clr",    1, 1, OP_CLR,  64'h0, 0, 0);
        applyStimulus("hold",   1, 1, OP_HOLD, 64'h0, 1, 1);
        for (int i = 0; i < 40; i++)
            applyStimulus("rand", 1, 1'($urandom_range(0, 3) != 0), op_e'($urandom_range(0, 7)),
                          {32'h0, $urandom}, 1'($urandom), 1'($urandom));
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
